// File: rtl/div_radix2_clz_core.sv
// Iterative radix-2 restoring unsigned divider. The CLZ difference aligns the divisor MSB with
// the dividend MSB up front, so only quotient-width iterations are spent.
module div_radix2_clz_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         dividend,
  input  logic [$clog2(DATA_WIDTH)-1:0] dividend_CLZ,
  input  logic [DATA_WIDTH-1:0]         divisor,
  input  logic [$clog2(DATA_WIDTH)-1:0] divisor_CLZ,
  input  logic                          divisor_is_zero,
  output logic [DATA_WIDTH-1:0]         quotient,
  output logic [DATA_WIDTH-1:0]         remainder,
  output logic                          done
);

  localparam int unsigned CLZ_W = $clog2(DATA_WIDTH);

  typedef enum logic {StIdle, StDivide} state_e;

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_div;
  logic [DATA_WIDTH-1:0] r_q;
  logic [CLZ_W-1:0]      r_cnt;

  logic [CLZ_W-1:0]      w_shift;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_nxt;
  logic [DATA_WIDTH-1:0] w_q_nxt;

  always_comb begin
    w_shift   = divisor_CLZ - dividend_CLZ;
    w_ge      = (r_rem >= r_div);
    w_rem_nxt = w_ge ? (r_rem - r_div) : r_rem;
    w_q_nxt   = {r_q[DATA_WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_rem     <= '0;
      r_div     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (divisor_is_zero) begin
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
            end else if (divisor_CLZ < dividend_CLZ) begin
              // Fewer leading zeros in the divisor means it is strictly larger.
              quotient  <= '0;
              remainder <= dividend;
              done      <= 1'b1;
            end else begin
              r_rem   <= dividend;
              r_div   <= divisor << w_shift;
              r_q     <= '0;
              r_cnt   <= w_shift;
              r_state <= StDivide;
            end
          end
        end
        StDivide: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_div <= r_div >> 1;
          if (r_cnt == '0) begin
            r_state   <= StIdle;
            quotient  <= w_q_nxt;
            remainder <= w_rem_nxt;
            done      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CLZ_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/div_radix2_clz_core.md
Name: div_radix2_clz_core

Overview:
- Iterative radix-2 restoring unsigned divider, used as the divider side of the unsigned division interface.
- Consumes a request from the div unit front end: dividend, divisor, their precomputed leading-zero counts, a divide-by-zero flag and a start strobe.
- Returns quotient, remainder and a one-cycle done pulse.
- Uses the CLZ difference to skip leading iterations, so latency scales with the quotient width rather than DATA_WIDTH.

Parameters:
- DATA_WIDTH, 32, operand/result width; CLZ fields are $clog2(DATA_WIDTH) bits.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-low (block in reset while rst==0)
- start  input  1  request strobe; only meaningful while idle
- dividend  input  DATA_WIDTH  unsigned dividend
- dividend_CLZ  input  $clog2(DATA_WIDTH)  leading zeros of dividend; zero operand encodes DATA_WIDTH-1
- divisor  input  DATA_WIDTH  unsigned divisor
- divisor_CLZ  input  $clog2(DATA_WIDTH)  leading zeros of divisor
- divisor_is_zero  input  1  divisor==0
- quotient  output  DATA_WIDTH  result quotient, held until next accepted start
- remainder  output  DATA_WIDTH  result remainder, held until next accepted start
- done  output  1  single-cycle pulse: quotient/remainder valid

Behaviour:
- Reset (rst==0, async): state=IDLE; quotient=0, remainder=0, done=0; counter and shifted divisor cleared. Reset asserted mid-operation aborts the division with no done pulse. Reset wins over a coincident start.
- States: IDLE, DIVIDE. Outputs are registered.
- IDLE, start=1 — classification, in priority order:
  - divisor_is_zero: quotient=all ones, remainder=dividend, done=1 next cycle; stay IDLE. Latency 1.
  - divisor_CLZ < dividend_CLZ (divisor > dividend): quotient=0, remainder=dividend, done=1 next cycle; stay IDLE. Latency 1.
  - Otherwise:
    - shift = divisor_CLZ - dividend_CLZ (0..DATA_WIDTH-1).
    - Load rem_r=dividend, div_r=divisor<<shift, q_r=0, cnt=shift.
    - Go to DIVIDE.
- DIVIDE, each cycle:
  - If rem_r >= div_r: rem_r -= div_r and shift 1 into q_r LSB; else shift 0 into q_r LSB.
  - div_r >>= 1.
  - If cnt==0: go to IDLE; next cycle quotient=q_r, remainder=rem_r, done=1. Else cnt -= 1.
  - Total iterations = shift+1; latency start-to-done = shift+2 cycles (2..DATA_WIDTH+1).
- Comparisons and subtraction are DATA_WIDTH-bit unsigned. div_r never overflows, because shift aligns the divisor MSB with the dividend MSB.
- done deasserts the cycle after it pulses.
- quotient/remainder change only when a done pulse is issued; they are stable between pulses.
- start while in DIVIDE is ignored. The requester must not issue it; the bench flags it as a protocol error via assertion.
- A start in the same cycle as done (state IDLE) is accepted, giving back-to-back operation with no bubble.
- Dividend==0 with nonzero divisor takes the normal path and yields q=0, r=0.
- Inputs are sampled only on the accepting cycle; they may change afterwards.

Test Plan:
- Normal path: dividend=100 (CLZ 25), divisor=7 (CLZ 29), start -> shift 4, done exactly 6 cycles later, quotient=14, remainder=2.
- Divide by zero: dividend=5, divisor=0, divisor_is_zero=1 -> done 1 cycle later, quotient=0xFFFFFFFF, remainder=5.
- Divisor > dividend: 3/10 (CLZ 30/28) -> done 1 cycle later, quotient=0, remainder=3. Separately, 0/1 -> latency 2, quotient=0, remainder=0.
- Worst case: 0xFFFFFFFF/1 (CLZ 0/31) -> done 33 cycles later, quotient=0xFFFFFFFF, remainder=0. Also 0x80000000/0x80000000 -> latency 2, quotient=1, remainder=0.
- Back-to-back: start 100/7, then start 50/3 in the done cycle -> second done 6 cycles later (shift 4) with quotient=16, remainder=2; first results held unchanged in between.
- Reset mid-op: start 0xFFFFFFFF/1, drop rst at cycle 10 -> outputs 0 immediately, no done pulse; after release, 9/4 -> done in 3 cycles, quotient=2, remainder=1.
